// File: rtl/sp_pkg.sv
// Shared definitions for the parallel/serial converter pair: state encoding,
// default frame width and the bit-counter width helper.
package sp_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } sp_state_e;

  localparam int C_SP_BITS = 255;

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int f_cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/p_s_bit_counter.sv
// Loadable down-counter with a zero flag; tracks remaining bits of a frame.
module p_s_bit_counter
  import sp_pkg::*;
#(
  parameter int C_CNT_W = 8
) (
  input  logic               i_ck,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [C_CNT_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic [C_CNT_W-1:0] o_cnt,
  output logic               o_zero
);

  logic [C_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_ck) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - C_CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/p_s_converter.sv
// Parallel-to-serial converter, MSB first, with FRAME/LAST strobes.
// Define P_S_BACK_TO_BACK_EN to allow a reload on the final bit (gapless frames).
//
// state   | meaning
// IDLE    | waiting for a word, LOAD_READY high, Q low
// SHIFT   | emitting a frame, one bit per clock
module p_s_converter
  import sp_pkg::*;
#(
  parameter int C_BITS_IN = C_SP_BITS
) (
  input  logic                 i_ck,
  input  logic                 i_rst,
  input  logic [C_BITS_IN-1:0] i_pd,
  input  logic                 i_load_valid,
  output logic                 o_load_ready,
  output logic                 o_q,
  output logic                 o_frame,
  output logic                 o_last,
  output logic                 o_busy
);

  localparam int C_CNT_W = f_cnt_w(C_BITS_IN);

  sp_state_e            r_state;
  sp_state_e            w_state_nxt;
  logic [C_BITS_IN-1:0] r_sr;
  logic                 r_frame;
  logic                 r_last;
  logic                 r_busy;
  logic                 w_ready;
  logic                 w_hs;
  logic                 w_dec;
  logic [C_CNT_W-1:0]   w_cnt;
  logic                 w_zero;

  p_s_bit_counter #(
    .C_CNT_W (C_CNT_W)
  ) u_bit_counter (
    .i_ck       (i_ck),
    .i_rst      (i_rst),
    .i_load     (w_hs),
    .i_load_val (C_CNT_W'(C_BITS_IN - 1)),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_ready = 1'b0;
    if (i_rst) begin
`ifdef P_S_BACK_TO_BACK_EN
      w_ready = (r_state == ST_IDLE) || w_zero;
`else
      w_ready = (r_state == ST_IDLE);
`endif
    end
  end

  assign w_hs  = i_load_valid & w_ready;
  assign w_dec = (r_state == ST_SHIFT) && !w_zero && !w_hs;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_hs) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_zero && !w_hs) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Zero-fill means the register is all zeros once a frame drains, so Q idles low.
  always_ff @(posedge i_ck) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_frame <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_sr    <= i_pd;
        r_frame <= 1'b1;
        r_last  <= 1'b0;
        r_busy  <= 1'b1;
      end else if (r_state == ST_SHIFT) begin
        r_sr    <= {r_sr[C_BITS_IN-2:0], 1'b0};
        r_frame <= 1'b0;
        r_last  <= (w_cnt == C_CNT_W'(1));
        r_busy  <= !w_zero;
      end
    end
  end

  assign o_load_ready = w_ready;
  assign o_q          = r_sr[C_BITS_IN-1];
  assign o_frame      = r_frame;
  assign o_last       = r_last;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_p_s_converter.sv
// Directed bench for p_s_converter at 8 bits; gap expectations follow
// whether P_S_BACK_TO_BACK_EN is defined.
module tb_p_s_converter;

`ifdef P_S_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  localparam int GAP = B2B ? 0 : 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pd;
  logic       valid;
  logic       ready;
  logic       q;
  logic       frame;
  logic       last;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  p_s_converter #(
    .C_BITS_IN (8)
  ) dut (
    .i_ck         (clk),
    .i_rst        (rst),
    .i_pd         (pd),
    .i_load_valid (valid),
    .o_load_ready (ready),
    .o_q          (q),
    .o_frame      (frame),
    .o_last       (last),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_q"}, q, 0);
    check({tag, "_frame"}, frame, 0);
    check({tag, "_last"}, last, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Handshake a word now, then check all 8 bits; pd is scrambled while busy.
  task automatic send_and_check(input string tag, input logic [7:0] word, input bit scramble);
    logic [7:0] acc;
    acc   = '0;
    pd    = word;
    valid = 1'b1;
    #1;
    check({tag, "_ready_idle"}, ready, 1);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (scramble) pd = 8'($urandom);
      #1;
      check({tag, "_q"}, q, word[7-i]);
      check({tag, "_frame"}, frame, (i == 0));
      check({tag, "_last"}, last, (i == 7));
      check({tag, "_busy"}, busy, 1);
      check({tag, "_ready"}, ready, B2B && (i == 7));
      acc = {acc[6:0], q};
      tick();
    end
    check({tag, "_downstream"}, acc, word);
    check_idle({tag, "_after"});
    check({tag, "_ready_after"}, ready, 1);
  endtask

  initial begin
    int f1;
    int f2;
    rst   = 1'b0;
    valid = 1'b1;
    pd    = 8'h5A;
    f1    = -1;
    f2    = -1;

    // Reset held with a valid word pending: nothing accepted.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("rst");
      check("rst_ready", ready, 0);
    end
    valid = 1'b0;
    rst   = 1'b1;
    #1;
    check("rst_release_ready", ready, 1);
    tick();
    check_idle("rst_no_accept");

    // Single frame.
    send_and_check("a5", 8'hA5, 1'b0);

    // Valid stuck high, two words.
    pd    = 8'hFF;
    valid = 1'b1;
    tick();
    pd = 8'h00;
    for (int t = 0; t < 16 + GAP; t++) begin
      if (t < 8) begin
        check("b2b_q1", q, 1);
        check("b2b_frame1", frame, (t == 0));
        check("b2b_last1", last, (t == 7));
        check("b2b_busy1", busy, 1);
        check("b2b_ready1", ready, B2B && (t == 7));
      end else if (t < 8 + GAP) begin
        check_idle("b2b_gap");
        check("b2b_gap_ready", ready, 1);
      end else begin
        check("b2b_q2", q, 0);
        check("b2b_frame2", frame, (t == 8 + GAP));
        check("b2b_last2", last, (t == 15 + GAP));
        check("b2b_busy2", busy, 1);
        check("b2b_ready2", ready, B2B && (t == 15 + GAP));
      end
      if (frame && f1 < 0) f1 = cyc;
      else if (frame) f2 = cyc;
      tick();
      if (t == 7 + GAP) valid = 1'b0;
    end
    check("b2b_frame_spacing", f2 - f1, 8 + GAP);
    check_idle("b2b_end");

    // Reset in the middle of a frame.
    pd    = 8'hC3;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("mid_q", q, (i < 2) ? 1 : 0);
      tick();
    end
    rst = 1'b0;
    #1;
    check("mid_rst_ready", ready, 0);
    tick();
    check_idle("mid_rst");
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("mid_post");
    end
    send_and_check("3c", 8'h3C, 1'b0);

    // Input word changing every cycle while busy.
    send_and_check("scr", 8'h96, 1'b1);
    send_and_check("scr2", 8'h01, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p_s_converter.md
Name: p_s_converter

Overview:
- Parallel-to-serial converter that sits directly upstream of the serial-to-parallel converter. It drives that stage's serial D input, one bit per CK.
- Accepts a C_BITS_IN-wide word through a valid/ready handshake and shifts it out MSB-first.
- After C_BITS_IN clocks, downstream Q[i] equals PD[i] of the accepted word.
- Provides FRAME and LAST strobes so the downstream ring counter and latch enable can be aligned and checked.

Parameters:
- C_BITS_IN, 255, word width and bits per frame; legal range >= 2; must equal downstream C_BITS_OUT.
- C_CNT_W, $clog2(C_BITS_IN), bit-counter width; derived, not overridden.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous active-low reset, sampled on CK rising edge.
- PD  input  C_BITS_IN  parallel word; sampled only on a handshake edge.
- LOAD_VALID  input  1  PD holds a word to send.
- LOAD_READY  output  1  block can accept a word this cycle.
- Q  output  1  serial data out; drives downstream D.
- FRAME  output  1  high during the cycle Q carries the first bit, PD[C_BITS_IN-1].
- LAST  output  1  high during the cycle Q carries the final bit, PD[0].
- BUSY  output  1  high while a frame is being shifted.

Behaviour:
- Reset: RST low at an edge puts the FSM in IDLE and clears the shift register and counter.
  - After that edge: Q=0, FRAME=0, LAST=0, BUSY=0.
  - LOAD_READY is forced 0 while RST is low.
  - Reset mid-frame aborts the frame immediately; no further bits are emitted.
- FSM states: IDLE, SHIFT.
  - IDLE: LOAD_READY=1, Q=0, BUSY=0.
  - Handshake = LOAD_VALID & LOAD_READY at a rising edge. On that edge: load PD into the shift register, set counter to C_BITS_IN-1, go to SHIFT.
  - SHIFT: Q = shift_reg MSB (registered output); BUSY=1.
    - Each edge shifts left by 1, filling 0 at the LSB, and decrements the counter.
    - FRAME=1 when counter==C_BITS_IN-1. LAST=1 when counter==0.
    - On the edge leaving counter==0, go to IDLE (with macro: see Optional Feature).
- Latency: the handshake at edge k makes Q=PD[C_BITS_IN-1] in the cycle after edge k. PD[0] appears in cycle k+C_BITS_IN.
- Frame length is exactly C_BITS_IN cycles. No start, stop or parity bits; framing is carried only by FRAME and LAST.
- PD and LOAD_VALID are ignored while LOAD_READY=0. A word held valid across the busy period is accepted on the first ready cycle.
- LOAD_VALID held permanently high (without macro) gives frames separated by exactly one idle cycle with Q=0.
- Simultaneous RST low and handshake: reset wins and the word is not accepted.
- Q, FRAME, LAST and BUSY are all registered (glitch-free into the downstream DFF chain). LOAD_READY is combinational from state, RST and counter.

Optional Feature:
- Macro: P_S_BACK_TO_BACK_EN.
- Defined:
  - LOAD_READY is also 1 in SHIFT when counter==0.
  - A handshake on that edge reloads the shift register and counter and stays in SHIFT.
  - The next cycle carries the new word's MSB with FRAME=1, giving zero-gap streaming and 100% line utilisation.
- Undefined: LOAD_READY=0 throughout SHIFT, and a minimum of one IDLE cycle separates frames.

Decomposition:
- Shared package sp_pkg (also used by the downstream converter and its bench):
  - State enum for IDLE/SHIFT.
  - Default width constant C_SP_BITS=255.
  - Counter-width helper function.
- One natural sub-module: p_s_bit_counter, a loadable down-counter with a zero flag, width C_CNT_W. The shift register and FSM stay in the top module.

Test Plan:
1. Reset: hold RST=0 for 3 edges with LOAD_VALID=1 -> Q=0, FRAME=0, LAST=0, BUSY=0, LOAD_READY=0 throughout, and no word accepted.
2. Single frame, C_BITS_IN=8, PD=8'hA5 -> Q sequence 1,0,1,0,0,1,0,1. FRAME only on the first bit, LAST only on the 8th. Downstream Q=8'hA5.
3. Back-to-back, macro off, LOAD_VALID stuck 1, words 8'hFF then 8'h00 -> 8 ones, 1 idle cycle (Q=0, LOAD_READY=1), 8 zeros. Next FRAME 9 cycles after the first.
4. Back-to-back, macro on, same stimulus -> 8 ones then 8 zeros with no gap. LOAD_READY=1 exactly in the LAST cycle; second FRAME exactly 8 cycles after the first.
5. Reset mid-frame: PD=8'hC3, RST=0 at bit 4 -> Q=0 and BUSY=0 from the next cycle. The next handshake with 8'h3C sends 0,0,1,1,1,1,0,0 cleanly.
6. PD change while busy: PD altered every cycle during SHIFT -> serial output still equals the word captured at the handshake.
